round_scheduler: RTL and testbench

ROUND_SCHEDULER -- requirements
Module: round_scheduler

---
 rtl/game_pkg.sv | 36 +++
 rtl/round_scheduler_if.sv | 18 +
 rtl/round_timer.sv | 31 +++
 rtl/round_scheduler.sv | 167 ++++++++++++++++
 tb/tb_round_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Purpose: shared state encoding, light constants and widths for the reaction-game round scheduler.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package game_pkg;

  localparam int LIGHT_W = 4;
  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_PICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HIT    = 3'd4,
    ST_MISS   = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  localparam logic [LIGHT_W-1:0] LIGHT_NONE = 4'b0000;
  localparam logic [LIGHT_W-1:0] LIGHT_0    = 4'b0001;
  localparam logic [LIGHT_W-1:0] LIGHT_1    = 4'b0010;
  localparam logic [LIGHT_W-1:0] LIGHT_2    = 4'b0100;
  localparam logic [LIGHT_W-1:0] LIGHT_3    = 4'b1000;
  localparam logic [LIGHT_W-1:0] LIGHT_ALL  = 4'b1111;

  // Map a 2-bit target index onto its one-hot light.
  function automatic logic [LIGHT_W-1:0] light_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return LIGHT_0;
      2'd1:    return LIGHT_1;
      2'd2:    return LIGHT_2;
      default: return LIGHT_3;
    endcase
  endfunction

endpackage

// File: rtl/round_scheduler_if.sv
// Purpose: groups the game control, button and display signals of the round scheduler.
// Latency: not applicable (wiring only).
// Backpressure: none; all signals are plain levels sampled every clk.
interface round_scheduler_if;
  import game_pkg::*;

  logic               start;
  logic [3:0]         rand_in;
  logic [LIGHT_W-1:0] buttons;
  logic [LIGHT_W-1:0] lights;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               done;

  modport master (output start, rand_in, buttons, input lights, score, busy, done);
  modport slave  (input start, rand_in, buttons, output lights, score, busy, done);

endinterface

// File: rtl/round_timer.sv
// Purpose: reaction-window countdown; loaded with the window, decremented while enabled.
// Latency: expired is combinational from the count register (high while count <= 1).
// Backpressure: none; enable simply pauses the count.
module round_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count_q;

  // Load wins over decrement; the count stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (enable && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  // The count equals 1 in the last cycle of the window.
  assign expired = (count_q <= W'(1));

endmodule

// File: rtl/round_scheduler.sv
// Purpose: reaction-game round scheduler: picks targets, times the window, scores hits (MISS_PENALTY_EN: misses cost a point).
// Latency: all outputs registered; a press in WAIT cycle N shows as HIT/MISS outputs in cycle N+1.
// Backpressure: none; start is only honoured in IDLE/FINISH, buttons are edge-detected every cycle.
module round_scheduler
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 10,
  parameter int BASE_TIMEOUT = 50000000,
  parameter int STEP         = 2500000,
  parameter int MIN_TIMEOUT  = 10000000
) (
  input logic              clk,
  input logic              rst,
  round_scheduler_if.slave bus
);

  localparam int TW = $clog2(BASE_TIMEOUT + 1);
  localparam logic [TW-1:0]      BASE_W = TW'(BASE_TIMEOUT);
  localparam logic [TW-1:0]      MIN_W  = TW'(MIN_TIMEOUT);
  localparam logic [TW-1:0]      STEP_W = TW'(STEP);
  localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [LIGHT_W-1:0] buttons_q;
  logic [LIGHT_W-1:0] press;
  logic [1:0]         target_q, target_d, pick_target;
  logic [1:0]         prev_q;
  logic               prev_vld_q;
  logic [TW-1:0]      window_q, window_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIGHT_W-1:0] lights_q, lights_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timer_expired;
  logic               wrong_press, right_press;
  logic               unused_rand;

  // Only the low two bits of the random word select a target.
  assign unused_rand = ^bus.rand_in[3:2];

  assign press       = bus.buttons & ~buttons_q;
  assign wrong_press = |(press & ~light_of(target_q));
  assign right_press = |(press & light_of(target_q));

  round_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state_q == ST_PICK),
    .value  (window_q),
    .enable (state_q == ST_WAIT),
    .expired(timer_expired)
  );

  // Never repeat the previous round's target: bump by one on collision.
  always_comb begin
    pick_target = bus.rand_in[1:0];
    if (prev_vld_q && pick_target == prev_q) begin
      pick_target = pick_target + 2'd1;
    end
    target_d = (state_q == ST_PICK) ? pick_target : target_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a wrong press beats a right one, any press beats expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_ARM;
      ST_ARM:    state_d = ST_PICK;
      ST_PICK:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (wrong_press)        state_d = ST_MISS;
        else if (right_press)   state_d = ST_HIT;
        else if (timer_expired) state_d = ST_MISS;
      end
      ST_HIT:    state_d = (score_q == WIN_S) ? ST_FINISH : ST_PICK;
      ST_MISS:   state_d = ST_PICK;
      ST_FINISH: if (bus.start) state_d = ST_ARM;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so they line up with it once registered.
  always_comb begin
    lights_d = LIGHT_NONE;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    case (state_d)
      ST_IDLE:   busy_d = 1'b0;
      ST_WAIT:   lights_d = light_of(target_d);
      ST_FINISH: begin
        lights_d = LIGHT_ALL;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Score follows the state being entered so HIT/MISS already show the new count.
  always_comb begin
    score_d = score_q;
    case (state_d)
      ST_ARM: score_d = '0;
      ST_HIT: score_d = score_q + 1'b1;
      ST_MISS: begin
`ifdef MISS_PENALTY_EN
        if (score_q != '0) score_d = score_q - 1'b1;
`else
        score_d = score_q;
`endif
      end
      default: ;
    endcase
  end

  // Window shrinks by STEP per hit down to MIN_TIMEOUT; compared wide so it cannot wrap.
  always_comb begin
    window_d = window_q;
    if (state_q == ST_ARM) begin
      window_d = BASE_W;
    end else if (state_q == ST_HIT && state_d == ST_PICK) begin
      if (33'(window_q) >= 33'(MIN_TIMEOUT) + 33'(STEP)) window_d = window_q - STEP_W;
      else                                              window_d = MIN_W;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      buttons_q  <= '0;
      target_q   <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      window_q   <= '0;
      score_q    <= '0;
      lights_q   <= LIGHT_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      buttons_q <= bus.buttons;
      target_q  <= target_d;
      window_q  <= window_d;
      score_q   <= score_d;
      lights_q  <= lights_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (state_q == ST_ARM) begin
        prev_vld_q <= 1'b0;
      end else if (state_q == ST_HIT || state_q == ST_MISS) begin
        prev_q     <= target_q;
        prev_vld_q <= 1'b1;
      end
    end
  end

  assign bus.lights = lights_q;
  assign bus.score  = score_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Purpose: directed self-checking bench for round_scheduler (two instances: STEP=4 and STEP=8).
// Latency: inputs driven and outputs sampled on the falling edge of clk.
// Backpressure: not applicable.
module tb_round_scheduler;

`ifdef MISS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] rand_in;
  logic [3:0] buttons;
  logic       sel;

  int n_tests = 0;
  int n_fail  = 0;

  round_scheduler_if if1();
  round_scheduler_if if2();

  assign if1.start   = start;
  assign if1.rand_in = rand_in;
  assign if1.buttons = buttons;
  assign if2.start   = start;
  assign if2.rand_in = rand_in;
  assign if2.buttons = buttons;

  round_scheduler #(.WIN_SCORE(3), .BASE_TIMEOUT(20), .STEP(4), .MIN_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus(if1)
  );

  round_scheduler #(.WIN_SCORE(5), .BASE_TIMEOUT(20), .STEP(8), .MIN_TIMEOUT(8)) dut_floor (
    .clk(clk), .rst(rst), .bus(if2)
  );

  logic [3:0] obs_lights, obs_score;
  logic       obs_busy, obs_done;
  assign obs_lights = sel ? if2.lights : if1.lights;
  assign obs_score  = sel ? if2.score  : if1.score;
  assign obs_busy   = sel ? if2.busy   : if1.busy;
  assign obs_done   = sel ? if2.done   : if1.done;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'b0;
    buttons = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the target light, then either let the window run out (press_at==0)
  // or press btn in WAIT cycle press_at. Returns at the HIT/MISS cycle.
  task automatic run_round(input string tag, input int press_at, input logic [3:0] btn,
                           input bit hold, output int lit, output logic [3:0] tgt);
    int k;
    k = 0;
    while (obs_lights == 4'b0000 && k < 64) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lit"}, 32'(obs_lights != 4'b0000), 32'd1);
    tgt = obs_lights;
    lit = 1;
    if (press_at == 0) begin
      while (obs_lights == tgt && lit < 64) begin
        @(negedge clk);
        if (obs_lights == tgt) lit++;
      end
    end else begin
      k = 1;
      while (k < press_at) begin
        @(negedge clk);
        k++;
        if (obs_lights == tgt) lit++;
      end
      buttons = btn;
      @(negedge clk);
      if (!hold) buttons = 4'b0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lit;
    logic [3:0] tgt;
    int         k;

    sel     = 1'b0;
    rand_in = 4'd2;
    do_reset();
    check("rst_lights", 32'(obs_lights), 32'd0);
    check("rst_score",  32'(obs_score),  32'd0);
    check("rst_busy",   32'(obs_busy),   32'd0);
    check("rst_done",   32'(obs_done),   32'd0);

    // Game A: hit in 3rd cycle, timeout, wrong double press, reset mid-WAIT.
    start_game();
    run_round("a1", 3, 4'b0100, 1'b0, lit, tgt);
    check("a1_tgt",    32'(tgt),        32'b0100);
    check("a1_len",    32'(lit),        32'd3);
    check("a1_score",  32'(obs_score),  32'd1);
    check("a1_lights", 32'(obs_lights), 32'd0);
    check("a1_busy",   32'(obs_busy),   32'd1);

    run_round("a2", 0, 4'b0000, 1'b0, lit, tgt);
    check("a2_tgt",   32'(tgt),       32'b1000);
    check("a2_len",   32'(lit),       32'd16);
    check("a2_score", 32'(obs_score), PEN ? 32'd0 : 32'd1);

    rand_in = 4'd1;
    run_round("a3", 1, 4'b0011, 1'b0, lit, tgt);
    check("a3_tgt",    32'(tgt),        32'b0010);
    check("a3_score",  32'(obs_score),  PEN ? 32'd0 : 32'd1);
    check("a3_lights", 32'(obs_lights), 32'd0);

    k = 0;
    while (obs_lights == 4'b0000 && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("a4_tgt", 32'(obs_lights), 32'b0100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_lights", 32'(obs_lights), 32'd0);
    check("midrst_score",  32'(obs_score),  32'd0);
    check("midrst_busy",   32'(obs_busy),   32'd0);
    check("midrst_done",   32'(obs_done),   32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_stays", 32'(obs_busy), 32'd0);

    // Game B: full timeout, press on last cycle, held button across rounds.
    do_reset();
    rand_in = 4'd0;
    start_game();
    run_round("b1", 0, 4'b0000, 1'b0, lit, tgt);
    check("b1_tgt",   32'(tgt),       32'b0001);
    check("b1_len",   32'(lit),       32'd20);
    check("b1_score", 32'(obs_score), 32'd0);

    run_round("b2", 20, 4'b0010, 1'b0, lit, tgt);
    check("b2_tgt",   32'(tgt),       32'b0010);
    check("b2_len",   32'(lit),       32'd20);
    check("b2_score", 32'(obs_score), 32'd1);

    run_round("b3", 16, 4'b0001, 1'b1, lit, tgt);
    check("b3_tgt",   32'(tgt),       32'b0001);
    check("b3_len",   32'(lit),       32'd16);
    check("b3_score", 32'(obs_score), 32'd2);

    run_round("b4", 0, 4'b0000, 1'b0, lit, tgt);
    check("b4_tgt",   32'(tgt),       32'b0010);
    check("b4_len",   32'(lit),       32'd12);
    check("b4_score", 32'(obs_score), PEN ? 32'd1 : 32'd2);
    buttons = 4'b0000;

    // Game C: three hits to FINISH, start held during play is ignored.
    do_reset();
    rand_in = 4'd3;
    start   = 1'b1;
    run_round("c1", 20, 4'b1000, 1'b0, lit, tgt);
    start = 1'b0;
    check("c1_tgt",   32'(tgt),       32'b1000);
    check("c1_len",   32'(lit),       32'd20);
    check("c1_score", 32'(obs_score), 32'd1);

    run_round("c2", 16, 4'b0001, 1'b0, lit, tgt);
    check("c2_tgt",   32'(tgt),       32'b0001);
    check("c2_len",   32'(lit),       32'd16);
    check("c2_score", 32'(obs_score), 32'd2);

    run_round("c3", 12, 4'b1000, 1'b0, lit, tgt);
    check("c3_tgt",   32'(tgt),       32'b1000);
    check("c3_len",   32'(lit),       32'd12);
    check("c3_score", 32'(obs_score), 32'd3);
    check("c3_busy",  32'(obs_busy),  32'd1);
    check("c3_done",  32'(obs_done),  32'd0);

    @(negedge clk);
    check("fin_done",   32'(obs_done),   32'd1);
    check("fin_lights", 32'(obs_lights), 32'b1111);
    check("fin_score",  32'(obs_score),  32'd3);
    check("fin_busy",   32'(obs_busy),   32'd0);
    repeat (2) @(negedge clk);
    check("fin_hold", 32'(obs_done), 32'd1);
    start_game();
    check("restart_score", 32'(obs_score), 32'd0);
    check("restart_done",  32'(obs_done),  32'd0);
    check("restart_busy",  32'(obs_busy),  32'd1);

    // Game D (STEP=8 instance): window 20, 12, 8, then stays at 8.
    sel = 1'b1;
    do_reset();
    rand_in = 4'd0;
    start_game();
    run_round("d1", 20, 4'b0001, 1'b0, lit, tgt);
    check("d1_score", 32'(obs_score), 32'd1);
    run_round("d2", 12, 4'b0010, 1'b0, lit, tgt);
    check("d2_len",   32'(lit),       32'd12);
    check("d2_score", 32'(obs_score), 32'd2);
    run_round("d3", 8, 4'b0001, 1'b0, lit, tgt);
    check("d3_len",   32'(lit),       32'd8);
    check("d3_score", 32'(obs_score), 32'd3);
    run_round("d4", 0, 4'b0000, 1'b0, lit, tgt);
    check("d4_tgt",   32'(tgt),       32'b0010);
    check("d4_len",   32'(lit),       32'd8);
    check("d4_score", 32'(obs_score), PEN ? 32'd2 : 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
